// File: rtl/path_delay_probe_pkg.sv
// Shared types and helpers for the path delay probe: FSM state encoding,
// default counter width / wait limit, and the saturating increment used by
// the latency counter.
package path_delay_probe_pkg;

    localparam int CW_DEFAULT      = 8;
    localparam int MAXWAIT_DEFAULT = 200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE
    } state_t;

    // Increment that sticks at 'limit' instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] limit);
        return (value >= limit) ? limit : value + 32'd1;
    endfunction

endpackage

// File: rtl/path_delay_probe_sync2.sv
// Two-flop synchronizer for the capture endpoint. Used only when the probe
// is built with PATH_DELAY_PROBE_SYNC_EN; adds exactly two cycles of latency.
module sync2 (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    // Two back-to-back data flops; no reset so the chain stays a pure delay.
    always_ff @(posedge clk) begin
        sync_p0 <= d;
        sync_p1 <= sync_p0;
    end

    assign q = sync_p1;

endmodule

// File: rtl/path_delay_probe.sv
// Launch/capture controller measuring path latency in clock cycles.
// Drives launch_q into a path, watches capture_d, and records last/min/max
// latency over a burst of alternating rise/fall launches.
// Optional build macro: PATH_DELAY_PROBE_SYNC_EN inserts a two-flop
// synchronizer on capture_d (every latency then grows by 2).
module path_delay_probe
    import path_delay_probe_pkg::*;
#(
    parameter int CW      = CW_DEFAULT,
    parameter int MAXWAIT = MAXWAIT_DEFAULT,
    parameter int SETTLE  = 4,
    parameter bit INVERT  = 1'b0
) (
    input  logic          C,
    input  logic          R,
    input  logic          start,
    input  logic [3:0]    runs,
    input  logic          capture_d,
    output logic          launch_q,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] lat_last,
    output logic [CW-1:0] lat_min,
    output logic [CW-1:0] lat_max
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CW) - 64'd1);
    localparam int          SW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [SW-1:0]   settle_cnt;
    logic [3:0]      runs_left;
    logic            cap;
    logic            match;
    logic            limit;
    logic            settle_last;

`ifdef PATH_DELAY_PROBE_SYNC_EN
    sync2 u_sync2 (
        .clk (C),
        .d   (capture_d),
        .q   (cap)
    );
`else
    assign cap = capture_d;
`endif

    assign cnt_inc     = CW'(sat_inc(32'(cnt), CNT_MAX));
    assign match       = (cap == (launch_q ^ INVERT));
    assign limit       = (sat_inc(32'(cnt), CNT_MAX) == 32'(MAXWAIT));
    assign settle_last = (settle_cnt == SW'(SETTLE - 1));

    assign busy = (state == ST_SETTLE) || (state == ST_LAUNCH) || (state == ST_WAIT);
    assign done = (state == ST_DONE);

    // State register.
    always_ff @(posedge C) begin
        if (R) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; a match in the same cycle as the limit takes priority.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (settle_last) begin
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (match) begin
                    state_nxt = (runs_left == 4'd1) ? ST_DONE : ST_SETTLE;
                end else if (limit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Launch flop, counters and latency results.
    always_ff @(posedge C) begin
        if (R) begin
            launch_q   <= 1'b0;
            timeout    <= 1'b0;
            lat_last   <= '0;
            lat_min    <= '1;
            lat_max    <= '0;
            runs_left  <= '0;
            cnt        <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        runs_left  <= (runs == 4'd0) ? 4'd1 : runs;
                        timeout    <= 1'b0;
                        lat_min    <= '1;
                        lat_max    <= '0;
                        settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + SW'(1);
                end
                ST_LAUNCH: begin
                    launch_q <= ~launch_q;
                    cnt      <= '0;
                end
                ST_WAIT: begin
                    cnt <= cnt_inc;
                    if (match) begin
                        lat_last   <= cnt_inc;
                        lat_min    <= (cnt_inc < lat_min) ? cnt_inc : lat_min;
                        lat_max    <= (cnt_inc > lat_max) ? cnt_inc : lat_max;
                        runs_left  <= runs_left - 4'd1;
                        settle_cnt <= '0;
                    end else if (limit) begin
                        timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_path_delay_probe.sv
// Bench for path_delay_probe: two probes (non-inverting and inverting path
// parity) each driving a bench-side delay line with independent rise/fall
// delays or a tied endpoint. Expected burst results come from a per-launch
// latency model (path stages + 1, plus synchronizer stages when built).
module tb_path_delay_probe;

    localparam int CW      = 8;
    localparam int MAXWAIT = 200;
    localparam int SETTLE  = 4;
`ifdef PATH_DELAY_PROBE_SYNC_EN
    localparam int SX = 2;
`else
    localparam int SX = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_s [2];
    logic [3:0]    runs_s  [2];
    logic          cap     [2];
    logic          lq      [2];
    logic          busy_s  [2];
    logic          done_s  [2];
    logic          to_s    [2];
    logic [CW-1:0] last_s  [2];
    logic [CW-1:0] min_s   [2];
    logic [CW-1:0] max_s   [2];

    int            p_dr   [2];
    int            p_df   [2];
    bit            p_inv  [2];
    bit            p_tie  [2];
    bit            p_tval [2];
    logic [15:0]   hreg   [2] = '{16'd0, 16'd0};

    int            m_lq   [2];
    int            m_last [2];
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    path_delay_probe #(.CW(CW), .MAXWAIT(MAXWAIT), .SETTLE(SETTLE), .INVERT(1'b0)) u_dut (
        .C(clk), .R(rst), .start(start_s[0]), .runs(runs_s[0]), .capture_d(cap[0]),
        .launch_q(lq[0]), .busy(busy_s[0]), .done(done_s[0]), .timeout(to_s[0]),
        .lat_last(last_s[0]), .lat_min(min_s[0]), .lat_max(max_s[0])
    );

    path_delay_probe #(.CW(CW), .MAXWAIT(MAXWAIT), .SETTLE(SETTLE), .INVERT(1'b1)) u_dut_inv (
        .C(clk), .R(rst), .start(start_s[1]), .runs(runs_s[1]), .capture_d(cap[1]),
        .launch_q(lq[1]), .busy(busy_s[1]), .done(done_s[1]), .timeout(to_s[1]),
        .lat_last(last_s[1]), .lat_min(min_s[1]), .lat_max(max_s[1])
    );

    // Bench-side path: launch_q delayed by d register stages (d=0 is a wire).
    function automatic logic tap(input logic cur, input logic [15:0] h, input int d);
        return (d == 0) ? cur : h[d-1];
    endfunction

    assign cap[0] = p_tie[0] ? p_tval[0]
                  : (tap(lq[0], hreg[0], lq[0] ? p_dr[0] : p_df[0]) ^ p_inv[0]);
    assign cap[1] = p_tie[1] ? p_tval[1]
                  : (tap(lq[1], hreg[1], lq[1] ? p_dr[1] : p_df[1]) ^ p_inv[1]);

    always @(posedge clk) begin
        hreg[0] <= {hreg[0][14:0], lq[0]};
        hreg[1] <= {hreg[1][14:0], lq[1]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One burst on probe i, checked against the latency model.
    task automatic run_burst(input int i, input int r, input int dr, input int df,
                             input bit inv, input bit tie, input bit tval,
                             input bit poke, input string tag);
        int lqm, nl, lat, cyc, emin, emax, elast, n;
        bit eto;
        p_dr[i] = dr; p_df[i] = df; p_inv[i] = inv; p_tie[i] = tie; p_tval[i] = tval;
        lqm = m_lq[i]; elast = m_last[i]; emin = 255; emax = 0; eto = 1'b0; cyc = 0;
        nl = (r == 0) ? 1 : r;
        for (int k = 0; k < nl; k++) begin
            lqm = lqm ^ 1;
            if (tie) lat = (int'(tval) == (lqm ^ int'(i == 1))) ? 1 : -1;
            else     lat = ((lqm == 1) ? dr : df) + 1 + SX;
            if (lat < 0 || lat > MAXWAIT) begin
                cyc += SETTLE + 1 + MAXWAIT;
                eto = 1'b1;
                break;
            end
            cyc += SETTLE + 1 + lat;
            elast = lat;
            if (lat < emin) emin = lat;
            if (lat > emax) emax = lat;
        end

        @(posedge clk); #1;
        start_s[i] = 1'b1; runs_s[i] = 4'(r);
        @(posedge clk); #1;
        start_s[i] = 1'b0;
        chk({tag, "_busy_rise"}, 32'(busy_s[i]), 32'd1);
        n = 0;
        while (n < 4000) begin
            @(posedge clk); #1;
            n++;
            if (poke && n == 3) begin start_s[i] = 1'b1; runs_s[i] = 4'd9; end
            if (poke && n == 4) start_s[i] = 1'b0;
            if (done_s[i]) break;
        end
        chk({tag, "_done_seen"}, 32'(done_s[i]), 32'd1);
        chk({tag, "_cycles"},    32'(n),         32'(cyc));
        chk({tag, "_busy_fall"}, 32'(busy_s[i]), 32'd0);
        chk({tag, "_timeout"},   32'(to_s[i]),   32'(eto));
        chk({tag, "_lat_last"},  32'(last_s[i]), 32'(elast));
        chk({tag, "_lat_min"},   32'(min_s[i]),  32'(emin));
        chk({tag, "_lat_max"},   32'(max_s[i]),  32'(emax));
        chk({tag, "_launch_q"},  32'(lq[i]),     32'(lqm));
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 32'(done_s[i]), 32'd0);
        m_lq[i] = lqm; m_last[i] = elast;
    endtask

    initial begin
        int n, old;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0; runs_s[i] = 4'd0;
            p_dr[i] = 0; p_df[i] = 0; p_inv[i] = bit'(i); p_tie[i] = 1'b0; p_tval[i] = 1'b0;
            m_lq[i] = 0; m_last[i] = 0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_launch_q", 32'(lq[i]),     32'd0);
            chk("rst_busy",     32'(busy_s[i]), 32'd0);
            chk("rst_done",     32'(done_s[i]), 32'd0);
            chk("rst_timeout",  32'(to_s[i]),   32'd0);
            chk("rst_lat_last", 32'(last_s[i]), 32'd0);
            chk("rst_lat_min",  32'(min_s[i]),  32'd255);
            chk("rst_lat_max",  32'(max_s[i]),  32'd0);
        end
        rst = 1'b0;

        run_burst(0, 4, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "loopback");
        run_burst(0, 2, 3, 3, 1'b0, 1'b0, 1'b0, 1'b0, "delay3");
        run_burst(1, 2, 2, 2, 1'b1, 1'b0, 1'b0, 1'b0, "invert2");
        run_burst(0, 2, 2, 5, 1'b0, 1'b0, 1'b0, 1'b0, "asym");
        run_burst(0, 1, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, "tied0");
        run_burst(0, 1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, "after_to");

        // Reset in the middle of a wait that would never match.
        p_tie[0] = 1'b1; p_tval[0] = bit'(m_lq[0]);
        old = m_lq[0];
        @(posedge clk); #1;
        start_s[0] = 1'b1; runs_s[0] = 4'd3;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        n = 0;
        while (n < 20 && int'(lq[0]) == old) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rstw_launched", 32'(lq[0]), 32'(old ^ 1));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstw_launch_q", 32'(lq[0]),     32'd0);
        chk("rstw_busy",     32'(busy_s[0]), 32'd0);
        chk("rstw_lat_min",  32'(min_s[0]),  32'd255);
        chk("rstw_lat_max",  32'(max_s[0]),  32'd0);
        chk("rstw_timeout",  32'(to_s[0]),   32'd0);
        chk("rstw_inv_busy", 32'(busy_s[1]), 32'd0);
        m_lq[0] = 0; m_last[0] = 0; m_lq[1] = 0; m_last[1] = 0;
        run_burst(0, 3, 1, 1, 1'b0, 1'b0, 1'b0, 1'b1, "post_rst");

        for (int t = 0; t < 14; t++) begin
            int i, r, dr, df;
            bit tie, tval;
            i    = int'($urandom_range(0, 1));
            r    = int'($urandom_range(0, 15));
            dr   = int'($urandom_range(0, 5));
            df   = int'($urandom_range(0, 5));
            tie  = ($urandom_range(0, 7) == 0);
            tval = bit'($urandom_range(0, 1));
            run_burst(i, r, dr, df, bit'(i), tie, tval, bit'($urandom_range(0, 1)),
                      $sformatf("rnd%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
